vga_pixel_unpack: RTL and testbench
===================================

// Module: vga_pixel_unpack
// PURPOSE
//  Consumer stage between the DDR3 read-data FIFO (128-bit, show-ahead, vga_clk side) and the VGA
//  timing/DAC outputs. Holds up to two FIFO words and serialises each word into PIX_PER_WORD
//  XRGB8888 pixels, one per pix_req. Detects and counts underflow. Optionally substitutes colour bars.
// PARAMETERS
//  PIX_PER_WORD   4            pixels per 128-bit word (fixed 32 bits/pixel; only 4 supported)
//  UNDERFLOW_RGB  24'hFF00FF   colour driven when a pixel is requested with no data held
//  H_ACTIVE       640          active pixels per line (test-pattern bar width = H_ACTIVE/8)
//  CNT_W          16           underflow counter width
// PORTS
//  vga_clk           in   1    pixel clock; all logic on its rising edge
//  vga_reset         in   1    synchronous, active-high reset
//  data_fifo_empty   in   1    FIFO empty; ddr_fifo_rd_data valid when low (show-ahead)
//  ddr_fifo_rd_data  in   128  FIFO head word
//  vga_rd_valid      out  1    FIFO pop strobe; head word captured in the same cycle
//  frame_start       in   1    1-cycle pulse at start of vertical blank
//  pix_req           in   1    one pixel demanded this cycle (active video)
//  test_pat          in   1    select colour bars (used only with VGA_TEST_PAT_EN)
//  pix_r/pix_g/pix_b out  8    pixel colour components
//  pix_valid         out  1    pix_r/g/b carry a requested pixel
//  underflow         out  1    sticky: an underflow occurred since the last frame_start
//  underflow_cnt     out  CNT_W saturating count of underflowed pixels since reset
// BEHAVIOUR
//  Reset: occ=0, lane=0, vga_rd_valid=0, pix_r/g/b=0, pix_valid=0, underflow=0, underflow_cnt=0.
//  Buffer: cur_word/nxt_word with occupancy occ in {0,1,2} (states EMPTY, ONE, TWO).
//  Pixel lane k = word[32k+31:32k]; R=[23:16], G=[15:8], B=[7:0]; [31:24] ignored. Lane 0 first.
//  Consume: pix_req && occ>0 -> emit lane 'lane' of cur_word; lane++. When lane==PIX_PER_WORD-1:
//   lane->0, cur_word<=nxt_word, occ decrements (word retired).
//  Pop (combinational): vga_rd_valid = !data_fifo_empty && (occ_after_retire < 2), where
//   occ_after_retire = occ - (word retired this cycle). Popped word loads into first free slot
//   after the shift. Retire and pop in the same cycle: occ unchanged, no bubble.
//  Never pops while data_fifo_empty=1; never exceeds occ=2.
//  Latency: pix_req at cycle N -> pix_valid=1 with pixel at N+1. pix_req=0 -> pix_valid=0 and
//   pix_r/g/b=0 next cycle (blanking drives black).
//  Underflow: pix_req && occ==0 -> pix_valid=1, pixel=UNDERFLOW_RGB, lane unchanged,
//   underflow<=1, underflow_cnt++ saturating at all-ones. A word popped in the same cycle is
//   loaded but not used for that pixel.
//  frame_start: lane<=0, underflow<=0 (counter kept). Partially consumed cur_word is dropped
//   (occ-1) if lane!=0, re-aligning to a word boundary. frame_start && pix_req same cycle:
//   frame_start wins, pixel treated as not requested (pix_valid=0).
//  Reset mid-frame: all state cleared next edge; no pop in reset cycle.
// CONFIGURATION
//  VGA_TEST_PAT_EN defined: x counter (cleared on frame_start and on pix_req falling edge,
//   +1 per pix_req); when test_pat=1 the pixel is 8 vertical bars of width H_ACTIVE/8:
//   white,yellow,cyan,green,magenta,red,blue,black. Buffer/pop/underflow logic runs unchanged
//   (FIFO keeps draining); underflow does not override bars.
//  Not defined: no x counter, test_pat ignored, pixels always from FIFO.
// STRUCTURE
//  Package vga_pkg: PIX_W=32, FIFO_W=128, rgb_t struct {r,g,b}, bar colour table constants,
//   occupancy state encoding.
//  Sub-module vga_colour_bars (x counter + bar lookup), instantiated only under VGA_TEST_PAT_EN.
// TESTING
//  1 Fill: FIFO holds words W0=0x00000004_00000003_00000002_00000001, W1; hold pix_req=0 ->
//    exactly 2 pops, occ=2, third word stays in FIFO.
//  2 Stream: pix_req continuous 8 cycles -> pixels B=0x01,0x02,0x03,0x04 then W1 lanes, pix_valid
//    1 cycle after each req; pop of W2 on W0 retire cycle; no gap.
//  3 Underflow: empty FIFO, pix_req 3 cycles -> 3x FF/00/FF, underflow=1, underflow_cnt=3;
//    frame_start -> underflow=0, cnt stays 3.
//  4 Realign: consume 2 lanes of W0, frame_start -> next pix_req yields W1 lane 0.
//  5 Saturation: CNT_W=4, 20 underflowed reqs -> underflow_cnt=15.
//  6 VGA_TEST_PAT_EN, test_pat=1, H_ACTIVE=640: pixel x=0 -> FF/FF/FF, x=80 -> FF/FF/00,
//    x=639 -> 00/00/00; FIFO still drains.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel unpack path: pixel/word widths, the RGB
// struct, the colour-bar table and the word-buffer occupancy encoding.
package vga_pkg;

  localparam int PIX_W  = 32;
  localparam int FIFO_W = 128;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Number of 128-bit words held in the cur/nxt buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
  localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
  localparam rgb_t BAR_CYAN    = 24'h00FFFF;
  localparam rgb_t BAR_GREEN   = 24'h00FF00;
  localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
  localparam rgb_t BAR_RED     = 24'hFF0000;
  localparam rgb_t BAR_BLUE    = 24'h0000FF;
  localparam rgb_t BAR_BLACK   = 24'h000000;

  // Bar index 0 is the leftmost bar.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_colour_bars.sv
// Colour-bar generator: counts active pixels along a line and maps the
// position onto eight equal-width vertical bars. Only built when
// VGA_TEST_PAT_EN is defined.
`ifdef VGA_TEST_PAT_EN
module vga_colour_bars
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic vga_clk,
  input  logic vga_reset,
  input  logic frame_start,
  input  logic pix_req,
  output rgb_t bar_rgb
);

  localparam int             X_W      = $clog2(H_ACTIVE) + 1;
  localparam logic [X_W-1:0] BAR_W    = X_W'(H_ACTIVE / 8);
  localparam logic [X_W-1:0] LAST_BAR = X_W'(7);

  logic [X_W-1:0] x;
  logic [X_W-1:0] bar_q;
  logic           pix_req_d;
  logic [2:0]     bar_idx;

  // x tracks the pixel being requested; it restarts every frame and every line.
  always_ff @(posedge vga_clk) begin
    if (vga_reset) begin
      x         <= '0;
      pix_req_d <= 1'b0;
    end else begin
      pix_req_d <= pix_req;
      if (frame_start)
        x <= '0;
      else if (pix_req)
        x <= x + 1'b1;
      else if (pix_req_d)
        x <= '0;
    end
  end

  // Positions past the last bar (overscan) stay on the last bar.
  always_comb begin
    bar_q   = x / BAR_W;
    bar_idx = (bar_q > LAST_BAR) ? 3'd7 : bar_q[2:0];
    bar_rgb = bar_colour(bar_idx);
  end

endmodule
`endif

// File: rtl/vga_pixel_unpack.sv
// Unpacks 128-bit DDR read words into XRGB8888 pixels for the VGA output.
// Two-word buffer (cur/nxt) fed from a show-ahead FIFO; one pixel per
// pix_req with one cycle latency; magenta + sticky flag on underflow.
// Optional colour bars when VGA_TEST_PAT_EN is defined.
module vga_pixel_unpack
  import vga_pkg::*;
#(
  parameter int          PIX_PER_WORD  = 4,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF,
  parameter int          H_ACTIVE      = 640,
  parameter int          CNT_W         = 16
) (
  input  logic              vga_clk,
  input  logic              vga_reset,
  input  logic              data_fifo_empty,
  input  logic [FIFO_W-1:0] ddr_fifo_rd_data,
  output logic              vga_rd_valid,
  input  logic              frame_start,
  input  logic              pix_req,
  input  logic              test_pat,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_valid,
  output logic              underflow,
  output logic [CNT_W-1:0]  underflow_cnt
);

  localparam int                LANE_W    = $clog2(PIX_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

  occ_t                                occ;
  logic [LANE_W-1:0]                   lane;
  logic [FIFO_W-1:0]                   cur_word;
  logic [FIFO_W-1:0]                   nxt_word;
  logic [PIX_PER_WORD-1:0][PIX_W-1:0]  cur_lanes;

  logic       req_eff, have_data, consume, retire, drop, pop, starve;
  logic [1:0] occ_after;
  rgb_t       lane_rgb, pix_sel;
  logic [7:0] unused_x_byte;

  assign cur_lanes                 = cur_word;
  assign {unused_x_byte, lane_rgb} = cur_lanes[lane];

`ifdef VGA_TEST_PAT_EN
  rgb_t bar_rgb;

  vga_colour_bars #(.H_ACTIVE(H_ACTIVE)) u_bars (
    .vga_clk     (vga_clk),
    .vga_reset   (vga_reset),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .bar_rgb     (bar_rgb)
  );
`else
  logic unused_test_pat;
  assign unused_test_pat = test_pat;
`endif

  // Consume/retire/pop decisions; frame_start masks the pixel request and
  // drops a partly used word so the next line starts on a word boundary.
  always_comb begin
    req_eff   = pix_req && !frame_start;
    have_data = (occ != OCC_EMPTY);
    consume   = req_eff && have_data;
    starve    = req_eff && !have_data;
    retire    = consume && (lane == LAST_LANE);
    drop      = frame_start && have_data && (lane != '0);
    occ_after = 2'(occ) - {1'b0, (retire || drop)};
    pop       = !vga_reset && !data_fifo_empty && (occ_after < 2'd2);
    pix_sel   = consume ? lane_rgb : rgb_t'(UNDERFLOW_RGB);
`ifdef VGA_TEST_PAT_EN
    if (test_pat) pix_sel = bar_rgb;
`endif
  end

  assign vga_rd_valid = pop;

  // Word buffer: shift nxt into cur on retire/drop, then load the popped
  // word into the first slot left free after the shift.
  always_ff @(posedge vga_clk) begin
    if (vga_reset) begin
      occ      <= OCC_EMPTY;
      lane     <= '0;
      cur_word <= '0;
      nxt_word <= '0;
    end else begin
      if (frame_start)
        lane <= '0;
      else if (consume)
        lane <= retire ? '0 : lane + 1'b1;
      if (retire || drop)
        cur_word <= nxt_word;
      if (pop) begin
        if (occ_after == 2'd0)
          cur_word <= ddr_fifo_rd_data;
        else
          nxt_word <= ddr_fifo_rd_data;
      end
      occ <= occ_t'(occ_after + {1'b0, pop});
    end
  end

  // Registered pixel output (black in blanking) and underflow tracking.
  always_ff @(posedge vga_clk) begin
    if (vga_reset) begin
      pix_valid     <= 1'b0;
      pix_r         <= '0;
      pix_g         <= '0;
      pix_b         <= '0;
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      pix_valid <= req_eff;
      {pix_r, pix_g, pix_b} <= req_eff ? pix_sel : '0;
      if (frame_start)
        underflow <= 1'b0;
      else if (starve)
        underflow <= 1'b1;
      if (starve && (underflow_cnt != '1))
        underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Directed bench for vga_pixel_unpack: queue-based show-ahead FIFO model,
// hand-computed pixel values, immediate assertions at each check point.
module tb_vga_pixel_unpack;

  logic         vga_clk = 1'b0;
  logic         vga_reset;
  logic         data_fifo_empty;
  logic [127:0] ddr_fifo_rd_data;
  logic         vga_rd_valid;
  logic         frame_start;
  logic         pix_req;
  logic         test_pat;
  logic [7:0]   pix_r, pix_g, pix_b;
  logic         pix_valid;
  logic         underflow;
  logic [3:0]   underflow_cnt;

  logic [127:0] fifo_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           pops   = 0;

  localparam logic [127:0] W0 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] W1 = 128'hFF102030_EE405060_DD708090_CCA0B0C0;
  localparam logic [127:0] W2 = 128'h000C0B0A_00090807_00060504_00030201;
  localparam logic [127:0] W3 = 128'h00FFEEDD_00CCBBAA_00998877_00665544;
  localparam logic [127:0] W4 = 128'h00000000_00000000_00000000_00123456;
  localparam logic [127:0] W5 = 128'h00FEDCBA_00000000_00000000_00ABCDEF;

  logic [23:0] exp_stream [8];

  always #5 vga_clk = ~vga_clk;

  vga_pixel_unpack #(
    .PIX_PER_WORD  (4),
    .UNDERFLOW_RGB (24'hFF00FF),
    .H_ACTIVE      (640),
    .CNT_W         (4)
  ) dut (
    .vga_clk          (vga_clk),
    .vga_reset        (vga_reset),
    .data_fifo_empty  (data_fifo_empty),
    .ddr_fifo_rd_data (ddr_fifo_rd_data),
    .vga_rd_valid     (vga_rd_valid),
    .frame_start      (frame_start),
    .pix_req          (pix_req),
    .test_pat         (test_pat),
    .pix_r            (pix_r),
    .pix_g            (pix_g),
    .pix_b            (pix_b),
    .pix_valid        (pix_valid),
    .underflow        (underflow),
    .underflow_cnt    (underflow_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic fifo_refresh();
    data_fifo_empty  = (fifo_q.size() == 0);
    ddr_fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [127:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  // One clock: sample the pop strobe mid-cycle, let the edge happen, then
  // retire the popped word from the FIFO model.
  task automatic tick();
    logic p;
    @(negedge vga_clk);
    p = vga_rd_valid;
    @(posedge vga_clk);
    #1;
    if (p) begin
      chk("pop_not_empty", 32'(fifo_q.size() > 0), 32'd1);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops++;
    end
    fifo_refresh();
  endtask

  function automatic logic [31:0] pix();
    return {8'h00, pix_r, pix_g, pix_b};
  endfunction

  initial begin
    exp_stream = '{24'h000001, 24'h000002, 24'h000003, 24'h000004,
                   24'hA0B0C0, 24'h708090, 24'h405060, 24'h102030};
    vga_reset   = 1'b1;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    test_pat    = 1'b0;
    fifo_refresh();
    push(W0); push(W1); push(W2);

    // Reset: no pops, outputs cleared.
    tick();
    chk("rst_no_pop", vga_rd_valid, 0);
    tick();
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix", pix(), 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_cnt", underflow_cnt, 0);
    chk("rst_fifo_kept", fifo_q.size(), 3);

    // Fill: exactly two pops, third word stays queued.
    vga_reset = 1'b0;
    #1 chk("fill_pop0", vga_rd_valid, 1);
    tick();
    chk("fill_pop1", vga_rd_valid, 1);
    tick();
    chk("fill_full", vga_rd_valid, 0);
    tick(); tick(); tick();
    chk("fill_pops", pops, 2);
    chk("fill_left", fifo_q.size(), 1);
    chk("fill_idle_valid", pix_valid, 0);

    // Stream: 8 back-to-back pixels, W2 popped on the W0 retire cycle.
    for (int i = 0; i < 8; i++) begin
      pix_req = 1'b1;
      #1;
      if (i == 3) chk("stream_pop_retire", vga_rd_valid, 1);
      else if (i < 3) chk("stream_no_pop", vga_rd_valid, 0);
      tick();
      chk("stream_valid", pix_valid, 1);
      chk("stream_pix", pix(), 32'(exp_stream[i]));
    end
    chk("stream_pops", pops, 3);
    pix_req = 1'b0;
    tick();
    chk("blank_valid", pix_valid, 0);
    chk("blank_black", pix(), 0);

    // Realign: two lanes of W2, then frame_start+pix_req drops the rest.
    push(W3);
    #1 chk("realign_pop", vga_rd_valid, 1);
    tick();
    pix_req = 1'b1;
    tick(); chk("realign_l0", pix(), 32'h030201);
    tick(); chk("realign_l1", pix(), 32'h060504);
    frame_start = 1'b1;
    tick();
    chk("fs_wins_valid", pix_valid, 0);
    chk("fs_wins_black", pix(), 0);
    frame_start = 1'b0;
    tick(); chk("realign_w3_l0", pix(), 32'h665544);
    tick(); chk("w3_l1", pix(), 32'h998877);
    tick(); chk("w3_l2", pix(), 32'hCCBBAA);
    tick(); chk("w3_l3", pix(), 32'hFFEEDD);

    // Underflow: buffer now empty.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("uf_valid", pix_valid, 1);
      chk("uf_pix", pix(), 32'hFF00FF);
      chk("uf_flag", underflow, 1);
      chk("uf_cnt", underflow_cnt, 32'(i + 1));
    end
    pix_req     = 1'b0;
    frame_start = 1'b1;
    tick();
    chk("fs_clr_flag", underflow, 0);
    chk("fs_keep_cnt", underflow_cnt, 3);
    frame_start = 1'b0;

    // Word popped during an underflowed pixel is kept for the next one.
    push(W4);
    pix_req = 1'b1;
    #1 chk("uf_pop", vga_rd_valid, 1);
    tick();
    chk("uf_pop_pix", pix(), 32'hFF00FF);
    chk("uf_pop_cnt", underflow_cnt, 4);
    tick();
    chk("uf_pop_next", pix(), 32'h123456);
    pix_req = 1'b0;
    tick();

    // Mid-frame reset with a word waiting and a request pending.
    push(W5);
    pix_req   = 1'b1;
    vga_reset = 1'b1;
    #1 chk("mrst_no_pop", vga_rd_valid, 0);
    tick();
    chk("mrst_valid", pix_valid, 0);
    chk("mrst_flag", underflow, 0);
    chk("mrst_cnt", underflow_cnt, 0);
    vga_reset = 1'b0;
    pix_req   = 1'b0;
    #1 chk("mrst_pop", vga_rd_valid, 1);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix_req     = 1'b1;
    tick(); chk("fs_lane0_keep", pix(), 32'hABCDEF);
    tick(); tick();
    tick(); chk("w5_l3", pix(), 32'hFEDCBA);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) chk("sat_cnt14", underflow_cnt, 14);
    end
    chk("sat_cnt15", underflow_cnt, 15);
    chk("sat_flag", underflow, 1);
    pix_req = 1'b0;
    tick();

`ifdef VGA_TEST_PAT_EN
    // Colour bars over one 640-pixel line; the FIFO keeps draining.
    test_pat    = 1'b1;
    frame_start = 1'b1;
    push(W0); push(W1);
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 640; i++) begin
      pix_req = 1'b1;
      tick();
      if (i == 0)   chk("bar_x0", pix(), 32'hFFFFFF);
      if (i == 80)  chk("bar_x80", pix(), 32'hFFFF00);
      if (i == 160) chk("bar_x160", pix(), 32'h00FFFF);
      if (i == 639) chk("bar_x639", pix(), 32'h000000);
      if (i == 639) chk("bar_valid", pix_valid, 1);
    end
    pix_req = 1'b0;
    tick();
    chk("bar_drained", fifo_q.size(), 0);
    test_pat = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
